// File: rtl/datapath_v1.sv
// datapath_v1: PC, IR, accumulator, register file, ALU and Z/C flags for the
// simple accumulator CPU. Executes the controller's one-cycle strobes.
module datapath_v1 #(
    parameter int unsigned DW   = 8,
    parameter int unsigned NREG = 16
) (
    input  logic          clk,
    input  logic          CLR,
    input  logic [DW+3:0] instr,
    input  logic          LoadIR,
    input  logic          IncPC,
    input  logic          SelPC,
    input  logic          LoadPC,
    input  logic          LoadReg,
    input  logic          LoadAcc,
    input  logic [1:0]    SelAcc,
    input  logic [3:0]    SelALU,
    output logic [DW-1:0] pc,
    output logic [3:0]    op,
    output logic          z,
    output logic          c,
    output logic [DW-1:0] acc
);

    localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_JZRS = 4'b0110;
    localparam logic [3:0] OP_JZIM = 4'b0111;
    localparam logic [3:0] OP_JCRS = 4'b1000;
    localparam logic [3:0] OP_JCIM = 4'b1010;
    localparam logic [3:0] OP_SHL  = 4'b1011;
    localparam logic [3:0] OP_SHR  = 4'b1100;

    logic [DW+3:0] ir_q, ir_d;
    logic [DW-1:0] pc_q, pc_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          z_q, z_d;
    logic          c_q, c_d;
    logic [DW-1:0] regs_q [NREG];

    logic [3:0]    op_w;
    logic [DW-1:0] operand;
    logic [IW-1:0] ridx;
    logic [DW-1:0] rop;
    logic [DW:0]   sum;
    logic [DW-1:0] alu_r;
    logic          alu_c;
    logic          jmp_take;

    assign op_w    = ir_q[DW+3:DW];
    assign operand = ir_q[DW-1:0];
    assign ridx    = operand[IW-1:0];
    assign rop     = regs_q[ridx];

    // ALU: operand A is ACC, operand B is the addressed register
    always_comb begin
        sum   = '0;
        alu_r = acc_q;
        alu_c = c_q;
        case (SelALU)
            OP_ADD: begin
                sum   = {1'b0, acc_q} + {1'b0, rop};
                alu_r = sum[DW-1:0];
                alu_c = sum[DW];
            end
            OP_SUB: begin
                // top bit of the widened difference is the borrow (ACC < B)
                sum   = {1'b0, acc_q} - {1'b0, rop};
                alu_r = sum[DW-1:0];
                alu_c = sum[DW];
            end
            OP_NOR: begin
                alu_r = ~(acc_q | rop);
                alu_c = 1'b0;
            end
            OP_SHL: begin
                alu_r = {acc_q[DW-2:0], 1'b0};
                alu_c = acc_q[DW-1];
            end
            OP_SHR: begin
                alu_r = {1'b0, acc_q[DW-1:1]};
                alu_c = acc_q[0];
            end
            default: begin
                alu_r = acc_q;
                alu_c = c_q;
            end
        endcase
    end

    // Next-state for IR, ACC, flags and PC
    always_comb begin
        ir_d  = ir_q;
        acc_d = acc_q;
        z_d   = z_q;
        c_d   = c_q;
        pc_d  = pc_q;

        if (LoadIR) begin
            ir_d = instr;
        end

        if (LoadAcc) begin
            case (SelAcc)
                2'b00: begin
                    acc_d = alu_r;
                    c_d   = alu_c;
                end
                2'b01:   acc_d = acc_q;
                2'b10:   acc_d = rop;
                default: acc_d = operand;
            endcase
            z_d = (acc_d == '0);
        end

        // a taken jump overrides IncPC; an untaken one lets IncPC through
        jmp_take = LoadPC &&
                   ((((op_w == OP_JZRS) || (op_w == OP_JZIM)) && z_q) ||
                    (((op_w == OP_JCRS) || (op_w == OP_JCIM)) && c_q));
        if (jmp_take) begin
            pc_d = SelPC ? rop : operand;
        end else if (IncPC) begin
            pc_d = pc_q + DW'(1);
        end
    end

    // Architectural state registers
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            ir_q  <= '0;
            pc_q  <= '0;
            acc_q <= '0;
            z_q   <= 1'b0;
            c_q   <= 1'b0;
        end else begin
            ir_q  <= ir_d;
            pc_q  <= pc_d;
            acc_q <= acc_d;
            z_q   <= z_d;
            c_q   <= c_d;
        end
    end

    // Register file; writes take the pre-edge ACC, reads see old data until the edge
    always_ff @(posedge clk or posedge CLR) begin
        if (CLR) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (LoadReg) begin
            regs_q[ridx] <= acc_q;
        end
    end

    assign pc  = pc_q;
    assign op  = op_w;
    assign z   = z_q;
    assign c   = c_q;
    assign acc = acc_q;

endmodule

// File: tb/tb_datapath_v1.sv
// Directed self-checking bench for datapath_v1 (DW=8, NREG=16).
module tb_datapath_v1;

    localparam int unsigned DW = 8;

    localparam logic [3:0] NOP  = 4'b0000;
    localparam logic [3:0] ADD  = 4'b0001;
    localparam logic [3:0] SUB  = 4'b0010;
    localparam logic [3:0] MOVR = 4'b0100;
    localparam logic [3:0] MOVA = 4'b0101;
    localparam logic [3:0] JZIM = 4'b0111;
    localparam logic [3:0] JCRS = 4'b1000;
    localparam logic [3:0] JCIM = 4'b1010;
    localparam logic [3:0] SHL  = 4'b1011;
    localparam logic [3:0] SHR  = 4'b1100;
    localparam logic [3:0] LDIM = 4'b1101;

    logic          clk = 1'b0;
    logic          CLR;
    logic [DW+3:0] instr;
    logic          LoadIR, IncPC, SelPC, LoadPC, LoadReg, LoadAcc;
    logic [1:0]    SelAcc;
    logic [3:0]    SelALU;
    logic [DW-1:0] pc;
    logic [3:0]    op;
    logic          z, c;
    logic [DW-1:0] acc;

    int checks = 0;
    int errors = 0;

    datapath_v1 #(.DW(DW), .NREG(16)) dut (
        .clk    (clk),
        .CLR    (CLR),
        .instr  (instr),
        .LoadIR (LoadIR),
        .IncPC  (IncPC),
        .SelPC  (SelPC),
        .LoadPC (LoadPC),
        .LoadReg(LoadReg),
        .LoadAcc(LoadAcc),
        .SelAcc (SelAcc),
        .SelALU (SelALU),
        .pc     (pc),
        .op     (op),
        .z      (z),
        .c      (c),
        .acc    (acc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock with the given strobes; returns 1ns after the edge
    task automatic step(input logic lir, input logic inc, input logic ldpc, input logic spc,
                        input logic lreg, input logic lacc, input logic [1:0] sa,
                        input logic [3:0] alu);
        LoadIR = lir; IncPC = inc; LoadPC = ldpc; SelPC = spc;
        LoadReg = lreg; LoadAcc = lacc; SelAcc = sa; SelALU = alu;
        @(posedge clk);
        #1;
        LoadIR = 0; IncPC = 0; LoadPC = 0; SelPC = 0;
        LoadReg = 0; LoadAcc = 0; SelAcc = 2'b01; SelALU = NOP;
    endtask

    task automatic ld_ir(input logic [3:0] o, input logic [7:0] opd);
        instr = {o, opd};
        step(1, 0, 0, 0, 0, 0, 2'b01, NOP);
    endtask

    task automatic ldim(input logic [7:0] v);
        ld_ir(LDIM, v);
        step(0, 0, 0, 0, 0, 1, 2'b11, LDIM);
    endtask

    task automatic alu_op(input logic [3:0] o, input logic [7:0] opd);
        ld_ir(o, opd);
        step(0, 0, 0, 0, 0, 1, 2'b00, o);
    endtask

    task automatic mova(input logic [7:0] r);
        ld_ir(MOVA, r);
        step(0, 0, 0, 0, 1, 0, 2'b01, MOVA);
    endtask

    task automatic movr(input logic [7:0] r);
        ld_ir(MOVR, r);
        step(0, 0, 0, 0, 0, 1, 2'b10, MOVR);
    endtask

    initial begin
        CLR = 1; instr = '0;
        LoadIR = 0; IncPC = 0; SelPC = 0; LoadPC = 0; LoadReg = 0; LoadAcc = 0;
        SelAcc = 2'b01; SelALU = NOP;
        repeat (2) @(posedge clk);
        #1 CLR = 0;
        @(posedge clk); #1;

        // build nonzero state: c=1, acc=0x55, r3=0x55, pc=2, op=MOVA
        ldim(8'h80);
        alu_op(SHL, 8'h00);
        ldim(8'h55);
        mova(8'h03);
        step(0, 1, 0, 0, 0, 0, 2'b01, NOP);
        step(0, 1, 0, 0, 0, 0, 2'b01, NOP);
        chk("pre_pc", pc, 16'h02);
        chk("pre_acc", acc, 16'h55);
        chk("pre_c", c, 16'h1);

        // asynchronous clear mid-cycle
        #2 CLR = 1;
        #1;
        chk("rst_pc", pc, 16'h00);
        chk("rst_op", op, 16'h0);
        chk("rst_acc", acc, 16'h00);
        chk("rst_z", z, 16'h0);
        chk("rst_c", c, 16'h0);
        #1 CLR = 0;
        @(posedge clk); #1;
        movr(8'h03);
        chk("rst_r3", acc, 16'h00);
        chk("rst_r3_z", z, 16'h1);

        // LDIM / ADD carry / SUB to zero
        ldim(8'h20);
        mova(8'h01);
        ldim(8'hF0);
        chk("ldim_acc", acc, 16'hF0);
        alu_op(ADD, 8'h01);
        chk("add_acc", acc, 16'h10);
        chk("add_c", c, 16'h1);
        chk("add_z", z, 16'h0);
        mova(8'h01);
        alu_op(SUB, 8'h01);
        chk("sub_acc", acc, 16'h00);
        chk("sub_z", z, 16'h1);
        chk("sub_c", c, 16'h0);

        // shift edges
        ldim(8'h81);
        alu_op(SHL, 8'h00);
        chk("shl_acc", acc, 16'h02);
        chk("shl_c", c, 16'h1);
        alu_op(SHR, 8'h00);
        chk("shr1_acc", acc, 16'h01);
        chk("shr1_c", c, 16'h0);
        alu_op(SHR, 8'h00);
        chk("shr2_acc", acc, 16'h00);
        chk("shr2_z", z, 16'h1);
        chk("shr2_c", c, 16'h1);

        // conditional jumps (z=1, c=1, pc=0 here)
        ld_ir(JZIM, 8'h40);
        step(0, 0, 1, 0, 0, 0, 2'b01, JZIM);
        chk("jz_taken", pc, 16'h40);
        ldim(8'h01);
        ld_ir(JZIM, 8'h40);
        step(0, 1, 0, 0, 0, 0, 2'b01, JZIM);
        step(0, 0, 1, 0, 0, 0, 2'b01, JZIM);
        chk("jz_fall", pc, 16'h41);
        ldim(8'h33);
        mova(8'h02);
        ld_ir(JCRS, 8'h02);
        step(0, 0, 1, 1, 0, 0, 2'b01, JCRS);
        chk("jc_reg", pc, 16'h33);
        ld_ir(LDIM, 8'h77);
        step(0, 0, 1, 0, 0, 0, 2'b01, LDIM);
        chk("nonjump_op", pc, 16'h33);

        // MOVA / MOVR (c is 1 going in)
        ldim(8'h5A);
        mova(8'h07);
        ldim(8'h00);
        chk("ldim0_z", z, 16'h1);
        chk("ldim0_c", c, 16'h1);
        movr(8'h07);
        chk("movr_acc", acc, 16'h5A);
        chk("movr_z", z, 16'h0);

        // same-edge LoadReg + LoadAcc: ALU sees old r7
        ldim(8'h11);
        ld_ir(ADD, 8'h07);
        step(0, 0, 0, 0, 1, 1, 2'b00, ADD);
        chk("simul_acc", acc, 16'h6B);
        chk("simul_c", c, 16'h0);
        movr(8'h07);
        chk("simul_r7", acc, 16'h11);

        // PC wrap and jump/IncPC priority
        ldim(8'h80);
        alu_op(SHL, 8'h00);
        ld_ir(JZIM, 8'hFF);
        step(0, 0, 1, 0, 0, 0, 2'b01, JZIM);
        chk("pc_ff", pc, 16'hFF);
        step(0, 1, 0, 0, 0, 0, 2'b01, NOP);
        chk("pc_wrap", pc, 16'h00);
        ld_ir(JCIM, 8'h10);
        step(0, 1, 1, 0, 0, 0, 2'b01, JCIM);
        chk("jmp_over_inc", pc, 16'h10);
        ldim(8'h01);
        ld_ir(JZIM, 8'h50);
        step(0, 1, 1, 0, 0, 0, 2'b01, JZIM);
        chk("untaken_inc", pc, 16'h11);
        chk("op_after_ir", op, 16'h7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/datapath_v1.md
# datapath_v1

Datapath for the simple accumulator CPU. It holds the program counter, instruction register, accumulator, register file, ALU and Z/C flags. It sits directly downstream of the multi-cycle controller and executes that controller's one-cycle load/select strobes. It returns the opcode and flags the controller branches on, and presents the PC to external instruction memory.

## Interface
Parameters:
- DW, 8, data/accumulator/PC width; instruction is {op[3:0], operand[DW-1:0]}.
- NREG, 16, register-file depth; register index = operand[3:0].

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- instr  input  DW+4  instruction word read from memory at pc.
- LoadIR  input  1  capture instr into IR.
- IncPC  input  1  PC <= PC+1.
- SelPC  input  1  jump target select: 1 = reg[operand[3:0]], 0 = immediate operand.
- LoadPC  input  1  jump request; taken only if the opcode's flag condition holds.
- LoadReg  input  1  reg[operand[3:0]] <= ACC.
- LoadAcc  input  1  ACC write enable.
- SelAcc  input  2  ACC source: 00 ALU, 01 hold, 10 reg[operand[3:0]], 11 immediate operand.
- SelALU  input  4  ALU function, opcode-coded.
- pc  output  DW  current PC (memory address).
- op  output  4  IR[DW+3:DW].
- z  output  1  registered zero flag.
- c  output  1  registered carry flag.
- acc  output  DW  current ACC (debug/observe).

## Operation
- Opcodes: NOP 0000, ADD 0001, SUB 0010, NOR 0011, MOVR 0100, MOVA 0101, JZRS 0110, JZIM 0111, JCRS 1000, JCIM 1010, SHL 1011, SHR 1100, LDIM 1101, HALT 1111.
- Immediate = operand (DW bits). Register operand = reg[operand[3:0]], combinational read.
- ALU (combinational; operand B = register operand):
  - ADD: {c,r} = ACC + B.
  - SUB: r = ACC - B, c = borrow (ACC < B).
  - NOR: r = ~(ACC | B), c = 0.
  - SHL: r = ACC << 1, c = ACC[DW-1].
  - SHR: r = ACC >> 1 (zero fill), c = ACC[0].
  - Any other code: r = ACC, c = current c.
- ACC write on LoadAcc:
  - Source per SelAcc. SelAcc 01 leaves ACC unchanged.
  - z <= (new ACC == 0), computed every time.
  - c <= ALU carry when SelAcc = 00; c is unchanged for 01/10/11.
- Flags change only on an LoadAcc edge.
- PC:
  - Jump taken = LoadPC & ((op in {JZRS,JZIM} & z) | (op in {JCRS,JCIM} & c)). Other opcodes never jump.
  - Jump taken: PC <= SelPC ? register operand : immediate.
  - LoadPC with condition false: PC holds. Its IncPC edge has already advanced PC, so this is fall-through.
  - If LoadPC and IncPC are both asserted: a taken jump wins; an untaken jump lets IncPC apply.
  - PC+1 wraps 2^DW-1 -> 0.
- LoadIR: IR <= instr. op updates after the edge.
- LoadReg: write occurs even if the index equals the register being read by another strobe in the same cycle. Reads see the old value until the edge.
- Strobes are independent. Simultaneous LoadIR/LoadAcc/LoadReg all take effect on the same edge.

## Timing
- CLR asserted: immediately, with no clock needed, PC=0, IR=0 (op=NOP), ACC=0, all registers=0, z=0, c=0. Hold while CLR is high.
- CLR released: first state change on the next rising edge with a strobe active.
- CLR mid-instruction: all state is discarded. No partial writes survive.
- Latencies:
  - Every strobe is registered. Effect is visible 1 cycle after the sampling edge.
  - The flag tested by LoadPC is the registered value at that edge, i.e. produced by an earlier instruction.
- pc, op, z, c, acc are register outputs with no combinational path from inputs.
- One instruction with the controller:
  - LoadIR cycle -> IncPC cycle -> execute cycle (LoadAcc, LoadReg or LoadPC).
  - 3 cycles total; 2 for NOP.

## Test plan
- Reset: assert CLR asynchronously mid-cycle after nonzero state -> pc=0, op=0000, acc=0, z=0, c=0 before the next edge; r3 reads 0.
- LDIM/ADD carry (DW=8): LDIM 0xF0, r1=0x20, ADD r1 -> acc=0x10, c=1, z=0. Then SUB r1 with r1=0x10 -> acc=0x00, z=1, c=0.
- SHL/SHR edges:
  - acc=0x81, SHL -> acc=0x02, c=1.
  - SHR -> acc=0x01, c=0.
  - SHR again -> acc=0x00, z=1, c=1.
- Conditional jumps:
  - z=1, JZIM 0x40 with LoadPC -> pc=0x40.
  - z=0, JZIM 0x40 -> pc holds at fall-through value.
  - c=1, JCRS r2 (r2=0x33), SelPC=1 -> pc=0x33.
- MOVA/MOVR:
  - acc=0x5A, MOVA r7 (LoadReg) -> r7=0x5A.
  - LDIM 0x00 -> z=1, c unchanged.
  - MOVR r7 -> acc=0x5A, z=0.
- PC wrap and priority:
  - pc=0xFF, IncPC -> pc=0x00.
  - LoadPC (taken, target 0x10) with IncPC asserted -> pc=0x10.
